// File: rtl/call_return_seq_pkg.sv
// Shared types and constants for the call/return sequencer.
package call_return_seq_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StPush,
    StPop,
    StDone
  } state_e;

  localparam int unsigned STACK_BYTE_W = 8;

  // Occupancy counter must represent 0..DEPTH inclusive.
  function automatic int unsigned depth_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/call_return_depth_ctr.sv
// Stack occupancy counter with frame-sized full/empty compares.
module call_return_depth_ctr
  import call_return_seq_pkg::*;
#(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned NB    = 2,
  parameter int unsigned DW    = depth_w(DEPTH)
) (
  input  logic          clk,
  input  logic          Reset,
  input  logic          inc_i,
  input  logic          dec_i,
  output logic [DW-1:0] depth_o,
  output logic          full_o,
  output logic          empty_o
);

  logic [DW-1:0] depth_q;

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      depth_q <= '0;
    end else if (inc_i && !dec_i) begin
      depth_q <= depth_q + 1'b1;
    end else if (dec_i && !inc_i) begin
      depth_q <= depth_q - 1'b1;
    end
  end

  // Extra bit keeps depth + NB from wrapping near capacity.
  assign full_o  = ({1'b0, depth_q} + (DW + 1)'(NB)) > (DW + 1)'(DEPTH);
  assign empty_o = depth_q < DW'(NB);
  assign depth_o = depth_q;

endmodule

// File: rtl/call_return_seq.sv
// Call/return sequencer: pushes a return address byte-serially on CALL and
// pops and reassembles it on RET, guarding against stack over/underflow.
module call_return_seq
  import call_return_seq_pkg::*;
#(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DEPTH  = 256
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic              call_req,
  input  logic [ADDR_W-1:0] call_addr,
  input  logic              ret_req,
  input  logic              err_clr,
  output logic              busy,
  output logic              ret_valid,
  output logic [ADDR_W-1:0] ret_addr,
  output logic              overflow_err,
  output logic              underflow_err,
  output logic              StackWrite,
  output logic [7:0]        StackDatain,
  output logic              StackRead,
  input  logic [7:0]        StackDataout
);

  localparam int unsigned NB   = ADDR_W / STACK_BYTE_W;
  localparam int unsigned CntW = (NB > 1) ? $clog2(NB) : 1;
  localparam int unsigned DW   = depth_w(DEPTH);
  localparam logic [CntW-1:0] LastCnt = CntW'(NB - 1);

  state_e            state_q;
  logic [CntW-1:0]   cnt_q, cnt_inc, pop_idx;
  logic [ADDR_W-1:0] addr_q, shift_q, shift_d, ret_addr_q;
  logic              busy_q, ret_valid_q, ovf_q, unf_q, wr_q, rd_q;
  logic [7:0]        din_q;
  logic              full, empty;
  logic [DW-1:0]     depth;

  assign cnt_inc = cnt_q + 1'b1;
  assign pop_idx = LastCnt - cnt_q;

  // MS byte comes off the stack first, so it fills the top lane first.
  always_comb begin
    shift_d = shift_q;
    shift_d[pop_idx * STACK_BYTE_W +: STACK_BYTE_W] = StackDataout;
  end

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      addr_q      <= '0;
      shift_q     <= '0;
      ret_addr_q  <= '0;
      busy_q      <= 1'b0;
      ret_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
      wr_q        <= 1'b0;
      rd_q        <= 1'b0;
      din_q       <= '0;
    end else begin
      ret_valid_q <= 1'b0;
      if (err_clr) begin
        ovf_q <= 1'b0;
        unf_q <= 1'b0;
      end
      unique case (state_q)
        StIdle, StDone: begin
          state_q <= StIdle;
          if (call_req) begin
            if (full) begin
              ovf_q <= 1'b1;
            end else begin
              addr_q  <= call_addr;
              cnt_q   <= '0;
              state_q <= StPush;
              busy_q  <= 1'b1;
              wr_q    <= 1'b1;
              din_q   <= call_addr[STACK_BYTE_W-1:0];
            end
          end else if (ret_req) begin
            if (empty) begin
              unf_q <= 1'b1;
            end else begin
              cnt_q   <= '0;
              state_q <= StPop;
              busy_q  <= 1'b1;
              rd_q    <= 1'b1;
            end
          end
        end
        StPush: begin
          if (cnt_q == LastCnt) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
            wr_q    <= 1'b0;
            din_q   <= '0;
          end else begin
            cnt_q <= cnt_inc;
            din_q <= addr_q[cnt_inc * STACK_BYTE_W +: STACK_BYTE_W];
          end
        end
        StPop: begin
          shift_q <= shift_d;
          if (cnt_q == LastCnt) begin
            state_q     <= StDone;
            busy_q      <= 1'b0;
            rd_q        <= 1'b0;
            ret_valid_q <= 1'b1;
            ret_addr_q  <= shift_d;
          end else begin
            cnt_q <= cnt_inc;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  call_return_depth_ctr #(
    .DEPTH (DEPTH),
    .NB    (NB),
    .DW    (DW)
  ) u_depth (
    .clk     (clk),
    .Reset   (Reset),
    .inc_i   (wr_q),
    .dec_i   (rd_q),
    .depth_o (depth),
    .full_o  (full),
    .empty_o (empty)
  );

  assign busy          = busy_q;
  assign ret_valid     = ret_valid_q;
  assign ret_addr      = ret_addr_q;
  assign overflow_err  = ovf_q;
  assign underflow_err = unf_q;
  assign StackWrite    = wr_q;
  assign StackDatain   = din_q;
  assign StackRead     = rd_q;

endmodule

// File: doc/call_return_seq.md
Name: call_return_seq

Overview:
- Subroutine call/return sequencer that acts as the initiator on the byte-wide stack port.
- On CALL it pushes a multi-byte return address one byte per cycle. On RET it pops the bytes back and reassembles the address for the PC.
- Sits between the control unit (call_req/ret_req) and the 8-bit stack memory.
- Tracks stack occupancy itself, so overflow and underflow are flagged before any stack access occurs.

Parameters:
- ADDR_W, 16, return-address width in bits; must be a multiple of 8. NB = ADDR_W/8 bytes per frame.
- DEPTH, 256, stack capacity in bytes; must match the attached stack.

Ports:
- clk  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-high reset.
- call_req  in  1  one-cycle request: push call_addr.
- call_addr  in  ADDR_W  return address, sampled in the cycle call_req is accepted.
- ret_req  in  1  one-cycle request: pop one return address.
- err_clr  in  1  clears the sticky error flags.
- busy  out  1  high while a push or pop sequence is in progress.
- ret_valid  out  1  one-cycle pulse; ret_addr is valid in this cycle.
- ret_addr  out  ADDR_W  reassembled return address; holds its value until the next pop completes.
- overflow_err  out  1  sticky: a CALL was refused because the stack is full.
- underflow_err  out  1  sticky: a RET was refused because the stack is empty.
- StackWrite  out  1  push strobe to the stack.
- StackDatain  out  8  byte being pushed.
- StackRead  out  1  read-and-pop strobe. The top-of-stack byte is returned combinationally in the same cycle; the stack drops that byte at the clock edge.
- StackDataout  in  8  top-of-stack byte from the stack.

Behaviour:
- Reset (async, immediate) → state IDLE, depth 0, byte counter 0. busy, ret_valid, ret_addr, overflow_err, underflow_err, StackWrite, StackRead and StackDatain are all 0. The stack memory must be reset in the same cycle.
- States: IDLE, PUSH, POP, DONE.
- Request acceptance: requests are only accepted in IDLE. Any request arriving while busy=1 is ignored, with no queueing.
- call_req and ret_req asserted together in IDLE → call_req wins; ret_req is dropped.
- Accepted call_req:
  - Refused if depth + NB > DEPTH: overflow_err ← 1, no stack strobes, remain in IDLE.
  - Otherwise call_addr is latched and the block goes to PUSH.
- PUSH:
  - Runs for NB cycles, with StackWrite=1 and busy=1 in each.
  - Bytes go out least-significant first: byte k = addr[8k+7:8k] for k=0..NB-1. The MS byte therefore ends on top.
  - depth increments by 1 per pushed byte.
  - After the last byte → IDLE. busy falls on the following cycle.
- Accepted ret_req:
  - Refused if depth < NB: underflow_err ← 1, no strobes, no ret_valid, remain in IDLE.
  - Otherwise the block goes to POP.
- POP:
  - Runs for NB cycles, with StackRead=1 and busy=1 in each.
  - StackDataout is captured at the edge of each pop cycle, MS byte first, into byte NB-1-k of the shift register.
  - depth decrements by 1 per popped byte.
  - After the last byte → DONE.
- DONE: lasts one cycle. ret_valid=1, ret_addr is updated, busy=0, next state IDLE. A new request may be accepted in the DONE cycle.
- Latency:
  - CALL: NB cycles of strobes, starting the cycle after call_req.
  - RET: ret_valid appears NB+1 cycles after ret_req.
- Strobes are mutually exclusive: StackWrite and StackRead are never high together. StackDatain = 0 whenever StackWrite = 0.
- depth range is 0..DEPTH, width clog2(DEPTH)+1; no wrap-around is ever possible.
- Error flags stay set until err_clr or Reset. If err_clr coincides with a new error in the same cycle, the flag is set (the new error wins).
- Reset asserted mid-PUSH or mid-POP aborts the sequence immediately. A partial frame is discarded because the stack is reset alongside.

Decomposition:
- Shared package holds:
  - the state enum (IDLE/PUSH/POP/DONE);
  - the STACK_BYTE_W=8 constant;
  - a clog2-based DEPTH_W function.
- Sub-module: call_return_depth_ctr. It is the occupancy counter with inc/dec inputs, full/empty-for-NB compare outputs and async reset.
- The byte shift register and FSM stay in the top module.

Test Plan:
- Single frame. After Reset, call_req with call_addr=16'h1234 → StackWrite for 2 cycles with StackDatain 8'h34 then 8'h12. Then ret_req → StackRead for 2 cycles, ret_valid one cycle later, ret_addr=16'h1234.
- Nesting. CALLs of 16'hAAAA, 16'hBBBB, 16'hCCCC followed by three RETs → ret_addr sequence CCCC, BBBB, AAAA; depth returns to 0.
- Underflow and error clearing:
  - ret_req right after Reset → underflow_err=1, no StackRead, no ret_valid.
  - err_clr → underflow_err=0.
- Overflow. 128 CALLs (depth=256), then one more call_req → overflow_err=1, no StackWrite; a subsequent RET still returns the 128th address.
- Collisions. call_req and ret_req together in IDLE → only the push occurs. A ret_req asserted during PUSH is ignored, and depth ends at 2.
- Reset mid-POP. Assert Reset in the first POP cycle → StackRead, busy and depth go to 0 immediately, with no ret_valid.
